piso_tx_sched: RTL and testbench

Scheduler that shares one parallel-in/serial-out shift register between NREQ word producers. It arbitrates round-robin, accepts one word per valid/ready handshake, and loads the word into the PISO. It then sequences exactly WIDTH shift cycles and flags each valid serial bit plus end-of-word. It sits between the producers and the PISO; the PISO's serial output goes straight to the consumer, qualified by ser_valid.

---
 rtl/piso_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/piso_tx_sched.sv | 118 +++++++++++
 tb/tb_piso_tx_sched.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared types, defaults and helpers for the PISO transmit scheduler
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_NREQ  = 2;

    function automatic int src_width(input int nreq);
        return (nreq > 2) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, priority starts just above ptr
module rr_arbiter
    import piso_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int PW   = src_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant
);

    logic found;

    // Walk offsets 1..NREQ from the pointer; the first active request wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && req[i] && (((int'(ptr) + k) % NREQ) == i)) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/piso_tx_sched.sv
// rtl/piso_tx_sched.sv - shares one PISO between NREQ producers: arbitrate, load, shift WIDTH bits
module piso_tx_sched
    import piso_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = DEF_NREQ
) (
    input  logic                         clk,
    input  logic                         clear,
    input  logic [NREQ-1:0]              req_valid,
    input  logic [NREQ*WIDTH-1:0]        req_data,
    output logic [NREQ-1:0]              req_ready,
    output logic                         piso_control,
    output logic [WIDTH-1:0]             piso_data,
    output logic                         ser_valid,
    output logic [src_width(NREQ)-1:0]   tx_src,
    output logic                         tx_done,
    output logic                         busy
);

    localparam int SW = src_width(NREQ);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hold;
    logic [SW-1:0]    ptr;
    logic [NREQ-1:0]  grant;
    logic [SW-1:0]    gidx;
    logic [WIDTH-1:0] gword;
    logic             xfer;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (SW)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant)
    );

    always_comb begin
        gidx  = '0;
        gword = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                gidx  = SW'(i);
                gword = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Grant only ever covers valid requesters, so a non-empty grant in IDLE is a handshake.
    assign xfer = (state == IDLE) && !clear && (grant != '0);

    always_ff @(posedge clk) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (xfer) state_nxt = LOAD;
            LOAD:    state_nxt = SHIFT;
            SHIFT:   if (cnt == LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            cnt    <= '0;
            hold   <= '0;
            ptr    <= SW'(NREQ - 1);
            tx_src <= '0;
        end else begin
            if (xfer) begin
                hold   <= gword;
                tx_src <= gidx;
                ptr    <= gidx;
            end
            if (state == LOAD) begin
                cnt <= '0;
            end else if (state == SHIFT) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Ready is masked by clear so a transfer never appears to happen on a reset edge.
    always_comb begin
        req_ready    = '0;
        piso_control = 1'b0;
        ser_valid    = 1'b0;
        tx_done      = 1'b0;
        busy         = 1'b0;
        case (state)
            IDLE:  req_ready = clear ? '0 : grant;
            LOAD:  busy = 1'b1;
            SHIFT: begin
                piso_control = 1'b1;
                ser_valid    = 1'b1;
                busy         = 1'b1;
                tx_done      = (cnt == LAST);
            end
            default: ;
        endcase
    end

    assign piso_data = hold;

endmodule

// File: tb/tb_piso_tx_sched.sv
// tb/tb_piso_tx_sched.sv - directed and randomized checks of piso_tx_sched against a transaction model
module tb_piso_tx_sched;

    localparam int W  = 4;
    localparam int N  = 2;
    localparam int W8 = 8;
    localparam int N8 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           clear;
    logic [N-1:0]   rv;
    logic [N*W-1:0] rd;
    logic [N-1:0]   ready;
    logic           ctrl;
    logic [W-1:0]   pdata;
    logic           sv;
    logic [0:0]     src;
    logic           done;
    logic           busy;

    logic             clear8;
    logic [N8-1:0]    rv8;
    logic [N8*W8-1:0] rd8;
    logic [N8-1:0]    ready8;
    logic             ctrl8;
    logic [W8-1:0]    pdata8;
    logic             sv8;
    logic [1:0]       src8;
    logic             done8;
    logic             busy8;

    piso_tx_sched #(.WIDTH(W), .NREQ(N)) dut (
        .clk          (clk),
        .clear        (clear),
        .req_valid    (rv),
        .req_data     (rd),
        .req_ready    (ready),
        .piso_control (ctrl),
        .piso_data    (pdata),
        .ser_valid    (sv),
        .tx_src       (src),
        .tx_done      (done),
        .busy         (busy)
    );

    piso_tx_sched #(.WIDTH(W8), .NREQ(N8)) dut8 (
        .clk          (clk),
        .clear        (clear8),
        .req_valid    (rv8),
        .req_data     (rd8),
        .req_ready    (ready8),
        .piso_control (ctrl8),
        .piso_data    (pdata8),
        .ser_valid    (sv8),
        .tx_src       (src8),
        .tx_done      (done8),
        .busy         (busy8)
    );

    // Behavioural PISOs, MSB shifted out first.
    logic [W-1:0]  shreg;
    logic [W8-1:0] shreg8;
    always @(posedge clk) begin
        if (clear) shreg <= '0;
        else if (!ctrl) shreg <= pdata;
        else shreg <= shreg << 1;
    end
    always @(posedge clk) begin
        if (clear8) shreg8 <= '0;
        else if (!ctrl8) shreg8 <= pdata8;
        else shreg8 <= shreg8 << 1;
    end

    int checks = 0;
    int errors = 0;

    // Transaction model: last granted index, cycles left of the current word, word held.
    int       m_ptr;
    int       m_left;
    int       m_src;
    logic [W-1:0] m_hold;
    bit       m_known;
    bit       rnd_mode;
    int       cyc;
    int       grant_log[$];
    int       grant_cyc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant();
        if (m_left != 0 || clear) return -1;
        for (int k = 1; k <= N; k++) begin
            if (rv[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic step();
        int g;
        int k;
        logic [N-1:0] eready;
        logic [W-1:0] word;
        @(negedge clk);
        g = model_grant();
        eready = '0;
        if (g >= 0) eready[g] = 1'b1;
        if (m_known) begin
            chk("req_ready", 32'(ready), 32'(eready));
            chk("busy", 32'(busy), 32'(m_left > 0));
            chk("piso_control", 32'(ctrl), 32'(m_left > 0 && m_left <= W));
            chk("ser_valid", 32'(sv), 32'(m_left > 0 && m_left <= W));
            chk("tx_done", 32'(done), 32'(m_left == 1));
            chk("piso_data", 32'(pdata), 32'(m_hold));
            chk("tx_src", 32'(src), 32'(m_src));
            if (m_left > 0 && m_left <= W) begin
                k = W - m_left;
                word = m_hold;
                chk("serial_bit", 32'(shreg[W-1]), 32'(word[W-1-k]));
            end
        end
        for (int i = 0; i < N; i++) begin
            if (ready[i] === 1'b1) begin
                grant_log.push_back(i);
                grant_cyc.push_back(cyc);
            end
        end
        @(posedge clk);
        if (clear) begin
            m_left  = 0;
            m_ptr   = N - 1;
            m_hold  = '0;
            m_src   = 0;
            m_known = 1'b1;
        end else if (m_left > 0) begin
            m_left--;
        end else if (g >= 0) begin
            m_hold = rd[g*W +: W];
            m_src  = g;
            m_ptr  = g;
            m_left = W + 1;
        end
        cyc++;
        #1;
        if (rnd_mode) begin
            for (int i = 0; i < N; i++) begin
                if (g == i || !rv[i]) begin
                    rv[i] = ($urandom_range(0, 2) != 0);
                    rd[i*W +: W] = W'($urandom);
                end else if ($urandom_range(0, 15) == 0) begin
                    rv[i] = 1'b0;
                end
            end
            clear = ($urandom_range(0, 63) == 0);
        end
    endtask

    initial begin
        int gl;
        int svc;
        int donec;
        int lastg;
        int bitk;
        logic [W8-1:0] w8;

        m_ptr = N - 1; m_left = 0; m_src = 0; m_hold = '0; m_known = 1'b0;
        rnd_mode = 1'b0; cyc = 0;
        clear8 = 1'b1; rv8 = '0; rd8 = '0;

        // Reset with both requesters valid.
        clear = 1'b1;
        rv = 2'b11;
        rd = {4'b0110, 4'b1110};
        step();
        step();

        // Single word from requester 0.
        clear = 1'b0;
        rv = 2'b01;
        grant_log.delete(); grant_cyc.delete();
        step();
        rv = 2'b00;
        repeat (W + 2) step();
        chk("single_grant_count", grant_log.size(), 1);

        // Fresh round-robin run: expect 0,1,0,1 spaced W+2 apart.
        clear = 1'b1;
        step();
        clear = 1'b0;
        rv = 2'b11;
        grant_log.delete(); grant_cyc.delete();
        repeat (4 * (W + 2)) step();
        chk("rr_grant_count", grant_log.size(), 4);
        if (grant_log.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("rr_grant_order", grant_log[i], i % 2);
            for (int i = 1; i < 4; i++) chk("rr_grant_spacing", grant_cyc[i] - grant_cyc[i-1], W + 2);
        end

        // Clear on the second shift cycle; next grant goes back to requester 0.
        step();
        step();
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        grant_log.delete(); grant_cyc.delete();
        step();
        gl = (grant_log.size() == 1) ? grant_log[0] : -1;
        chk("grant_after_clear", gl, 0);

        // Randomized traffic with occasional clears.
        rnd_mode = 1'b1;
        repeat (600) step();
        rnd_mode = 1'b0;
        clear = 1'b0;
        rv = '0;
        step();

        // WIDTH=8, NREQ=3, all valid.
        rv8 = 3'b111;
        for (int i = 0; i < N8; i++) rd8[i*W8 +: W8] = W8'($urandom);
        @(posedge clk);
        #1;
        clear8 = 1'b0;
        grant_log.delete();
        svc = 0; donec = 0; lastg = -1; bitk = 0; w8 = '0;
        for (int c = 0; c < 4 * (W8 + 2); c++) begin
            @(negedge clk);
            for (int i = 0; i < N8; i++) begin
                if (ready8[i] === 1'b1) begin
                    grant_log.push_back(i);
                    lastg = i;
                    w8 = rd8[i*W8 +: W8];
                    bitk = 0;
                end
            end
            if (sv8 === 1'b1) begin
                svc++;
                chk("sweep_src", 32'(src8), lastg);
                chk("sweep_bit", 32'(shreg8[W8-1]), 32'(w8[W8-1-bitk]));
                chk("sweep_done", 32'(done8), 32'(bitk == W8 - 1));
                bitk++;
            end
            if (done8 === 1'b1) donec++;
        end
        chk("sweep_ser_valid_cycles", svc, 4 * W8);
        chk("sweep_tx_done_count", donec, 4);
        chk("sweep_grant_count", grant_log.size(), 4);
        if (grant_log.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("sweep_grant_order", grant_log[i], i % N8);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
